// File: rtl/memory_stage.sv
// MEM stage of the 5-stage RV32I core: data-memory handshake, store lane
// formatting, load extraction, and pipeline stall generation.
module memory_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_out,
    input  logic [31:0] store_data,
    input  logic        flush,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_strb,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        stall,
    output logic        out_valid,
    output logic [31:0] dload,
    output logic        misaligned,
    output logic        bus_err
);

    localparam int unsigned CNT_W   = 32;
    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_req;
    logic               r_we;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [3:0]         r_strb;
    logic [2:0]         r_funct3;
    logic [1:0]         r_lane;
    logic [31:0]        r_dload;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_kill;

    logic               w_acc;
    logic               w_fault;
    logic               w_timeout;
    logic [31:0]        w_wdata;
    logic [3:0]         w_strb;
    logic [31:0]        w_load;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;

    // Access qualification and alignment fault detection on the incoming instruction
    always_comb begin
        w_acc   = in_valid & (mem_rd | mem_wr) & ~flush;
        w_fault = 1'b0;
        case (funct3[1:0])
            2'b00:   w_fault = 1'b0;
            2'b01:   w_fault = alu_out[0];
            2'b10:   w_fault = |alu_out[1:0];
            default: w_fault = 1'b1;
        endcase
        if (funct3 == 3'b110) begin
            w_fault = 1'b1;
        end
    end

    // Store lane replication and byte strobes; loads always fetch the full word
    always_comb begin
        w_wdata = store_data;
        w_strb  = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                w_wdata = {4{store_data[7:0]}};
                w_strb  = 4'b0001 << alu_out[1:0];
            end
            2'b01: begin
                w_wdata = {2{store_data[15:0]}};
                w_strb  = 4'b0011 << alu_out[1:0];
            end
            default: begin
                w_wdata = store_data;
                w_strb  = 4'b1111;
            end
        endcase
        if (!mem_wr) begin
            w_strb = 4'b1111;
        end
    end

    // Load lane select and sign/zero extension from the held access attributes
    always_comb begin
        w_byte = dmem_rdata[7:0];
        case (r_lane)
            2'd0:    w_byte = dmem_rdata[7:0];
            2'd1:    w_byte = dmem_rdata[15:8];
            2'd2:    w_byte = dmem_rdata[23:16];
            default: w_byte = dmem_rdata[31:24];
        endcase
        w_half = r_lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load = {24'd0, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = dmem_rdata;
        endcase
    end

    // Bus wait-time expiry while a request is outstanding
    always_comb begin
        w_timeout = TO_EN && (r_state == S_BUSY) && !dmem_ready
                    && (r_cnt == CNT_W'(TO_LAST));
    end

    // State machine and registered bus/load outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_strb   <= 4'd0;
            r_funct3 <= 3'd0;
            r_lane   <= 2'd0;
            r_dload  <= 32'd0;
            r_cnt    <= '0;
            r_kill   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt  <= '0;
                    r_kill <= 1'b0;
                    if (w_acc && !w_fault) begin
                        r_state  <= S_BUSY;
                        r_req    <= 1'b1;
                        r_we     <= mem_wr;
                        r_addr   <= {alu_out[31:2], 2'b00};
                        r_wdata  <= w_wdata;
                        r_strb   <= w_strb;
                        r_funct3 <= funct3;
                        r_lane   <= alu_out[1:0];
                    end
                end
                S_BUSY: begin
                    if (flush) begin
                        r_kill <= 1'b1;
                    end
                    if (dmem_ready) begin
                        r_req   <= 1'b0;
                        r_state <= S_DONE;
                        if (!r_we) begin
                            r_dload <= w_load;
                        end
                    end else if (w_timeout) begin
                        r_req   <= 1'b0;
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_kill  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_kill  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    // Pipeline control and fault pulses, decoded from state and the live instruction
    always_comb begin
        stall      = 1'b0;
        out_valid  = 1'b0;
        misaligned = 1'b0;
        bus_err    = 1'b0;
        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        if (w_fault) begin
                            misaligned = 1'b1;
                        end else begin
                            stall = 1'b1;
                        end
                    end else begin
                        out_valid = in_valid & ~flush;
                    end
                end
                S_BUSY: begin
                    if (w_timeout) begin
                        bus_err = 1'b1;
                    end else begin
                        stall = 1'b1;
                    end
                end
                S_DONE: begin
                    out_valid = ~r_kill & ~flush;
                end
                default: begin
                    stall = 1'b0;
                end
            endcase
        end
    end

    assign dmem_req   = r_req;
    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_wdata;
    assign dmem_strb  = r_strb;
    assign dload      = r_dload;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: the driver predicts events from a
// behavioural model and queues them; the monitor pops and compares.
module tb_memory_stage;

    localparam int TO = 4;

    localparam int EV_REQ  = 0;
    localparam int EV_VAL  = 1;
    localparam int EV_MIS  = 2;
    localparam int EV_BERR = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        mem_rd = 1'b0;
    logic        mem_wr = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] alu_out = 32'd0;
    logic [31:0] store_data = 32'd0;
    logic        flush = 1'b0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_strb;
    logic [31:0] dmem_rdata = 32'd0;
    logic        dmem_ready = 1'b0;
    logic        stall;
    logic        out_valid;
    logic [31:0] dload;
    logic        misaligned;
    logic        bus_err;

    memory_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .funct3(funct3), .alu_out(alu_out), .store_data(store_data), .flush(flush),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_strb(dmem_strb), .dmem_rdata(dmem_rdata),
        .dmem_ready(dmem_ready), .stall(stall), .out_valid(out_valid), .dload(dload),
        .misaligned(misaligned), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        bit          chk_dload;
        bit          chk_wdata;
        logic [31:0] dload;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        we;
    } ev_t;

    ev_t q[$];
    int checks = 0;
    int errors = 0;
    logic [31:0] m_dload = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit m_fault(input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
        return (int'(a % 4) % nbytes(f3)) != 0;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
        case (nbytes(f3))
            1:       return {24'd0, sd[7:0]} * 32'h0101_0101;
            2:       return {16'd0, sd[15:0]} * 32'h0001_0001;
            default: return sd;
        endcase
    endfunction

    function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
        int v;
        v = ((1 << nbytes(f3)) - 1) << int'(a % 4);
        return 4'(v);
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] w);
        int          bits;
        logic [31:0] v;
        logic [31:0] lim;
        bits = 8 * nbytes(f3);
        if (bits >= 32) return w;
        v   = (w >> (8 * int'(a % 4))) & ((32'd1 << bits) - 32'd1);
        lim = 32'd1 << (bits - 1);
        if (!f3[2] && v >= lim) v = v - (32'd1 << bits);
        return v;
    endfunction

    // ---------------- driver ----------------
    // fmode: 0 none, 1 flush on first cycle, 2 flush on BUSY cycle fbusy, 3 flush in DONE
    task automatic issue(input bit is_mem, input bit is_st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sd,
                         input logic [31:0] rword, input int waitc,
                         input int fmode, input int fbusy);
        ev_t e;
        int  exp_stall;
        int  stalls;
        int  busy;
        bit  rdy_prev;
        bit  done;
        exp_stall = 0;
        if (!is_mem) begin
            if (fmode != 1) begin
                e = '{kind: EV_VAL, chk_dload: 1'b0, chk_wdata: 1'b0, dload: 32'd0,
                      addr: 32'd0, wdata: 32'd0, strb: 4'd0, we: 1'b0};
                q.push_back(e);
            end
        end else if (fmode != 1) begin
            if (m_fault(f3, addr)) begin
                e = '{kind: EV_MIS, chk_dload: 1'b0, chk_wdata: 1'b0, dload: 32'd0,
                      addr: 32'd0, wdata: 32'd0, strb: 4'd0, we: 1'b0};
                q.push_back(e);
            end else begin
                e = '{kind: EV_REQ, chk_dload: 1'b0, chk_wdata: is_st, dload: 32'd0,
                      addr: addr & ~32'd3, wdata: m_wdata(f3, sd),
                      strb: is_st ? m_strb(f3, addr) : 4'hF, we: is_st};
                q.push_back(e);
                if (waitc >= TO) begin
                    exp_stall = TO;
                    e.kind = EV_BERR;
                    q.push_back(e);
                end else begin
                    exp_stall = waitc + 2;
                    if (!is_st) m_dload = m_load(f3, addr, rword);
                    if (!(fmode == 2 && fbusy <= waitc + 1) && fmode != 3) begin
                        e.kind = EV_VAL;
                        e.chk_dload = 1'b1;
                        e.dload = m_dload;
                        q.push_back(e);
                    end
                end
            end
        end

        @(posedge clk); #1;
        in_valid   = 1'b1;
        mem_rd     = is_mem & ~is_st;
        mem_wr     = is_mem & is_st;
        funct3     = f3;
        alu_out    = addr;
        store_data = sd;
        flush      = (fmode == 1);
        dmem_ready = 1'($urandom % 2);
        dmem_rdata = $urandom;
        busy = 0; rdy_prev = 1'b0; stalls = 0; done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                flush = 1'b0;
                if (dmem_req) begin
                    busy++;
                    dmem_ready = (busy == waitc + 1);
                    dmem_rdata = dmem_ready ? rword : $urandom;
                    flush      = (fmode == 2 && busy == fbusy);
                end else begin
                    dmem_ready = 1'($urandom % 2);
                    dmem_rdata = $urandom;
                    flush      = (fmode == 3 && rdy_prev);
                end
                rdy_prev = dmem_req && dmem_ready;
            end
            @(negedge clk);
            if (stall) stalls++;
            else done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL stall_bound: instruction never released the pipeline");
        end
        chk("stall_cycles", 32'(stalls), 32'(exp_stall));
    endtask

    task automatic bubble();
        @(posedge clk); #1;
        in_valid   = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        flush      = 1'($urandom % 2);
        dmem_ready = 1'($urandom % 2);
        dmem_rdata = $urandom;
        @(negedge clk);
        chk("bubble_stall", 32'(stall), 32'd0);
    endtask

    // ---------------- monitor ----------------
    bit   req_prev = 1'b0;
    bit   berr_prev = 1'b0;
    ev_t  cur_req;

    task automatic pop(input int kind, output ev_t e, output bit ok);
        checks++;
        ok = 1'b0;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind %0d expected none at %0t", kind, $time);
        end else begin
            e = q.pop_front();
            if (e.kind != kind) begin
                errors++;
                $display("FAIL event_kind: got %0d expected %0d at %0t", kind, e.kind, $time);
            end else begin
                ok = 1'b1;
            end
        end
    endtask

    always @(negedge clk) begin
        ev_t e;
        bit  ok;
        if (rst) begin
            req_prev  = 1'b0;
            berr_prev = 1'b0;
        end else begin
            if (berr_prev) chk("req_after_berr", 32'(dmem_req), 32'd0);
            if (dmem_req && !req_prev) begin
                pop(EV_REQ, e, ok);
                if (ok) begin
                    chk("req_addr", dmem_addr, e.addr);
                    chk("req_we", 32'(dmem_we), 32'(e.we));
                    chk("req_strb", 32'(dmem_strb), 32'(e.strb));
                    if (e.chk_wdata) chk("req_wdata", dmem_wdata, e.wdata);
                end
                cur_req = '{kind: EV_REQ, chk_dload: 1'b0, chk_wdata: 1'b0, dload: 32'd0,
                            addr: dmem_addr, wdata: dmem_wdata, strb: dmem_strb, we: dmem_we};
            end else if (dmem_req) begin
                chk("busy_hold", {dmem_addr ^ cur_req.addr} | {dmem_wdata ^ cur_req.wdata}
                    | 32'({dmem_strb ^ cur_req.strb, dmem_we ^ cur_req.we}), 32'd0);
            end
            if (out_valid) begin
                pop(EV_VAL, e, ok);
                if (ok && e.chk_dload) chk("dload", dload, e.dload);
            end
            if (misaligned) pop(EV_MIS, e, ok);
            if (bus_err)    pop(EV_BERR, e, ok);
            req_prev  = dmem_req;
            berr_prev = bus_err;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit          is_mem;
        bit          is_st;
        logic [2:0]  f3;
        logic [31:0] a;
        int          w;
        int          fm;
        int          fb;
        int          r;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 32'({dmem_req, dmem_we, stall, out_valid, misaligned, bus_err}), 32'd0);
        chk("reset_dload", dload, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        issue(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1, 0, 0);
        issue(1, 0, 3'b000, 32'h103, 32'h0, 32'h80123456, 0, 0, 0);
        issue(1, 0, 3'b100, 32'h103, 32'h0, 32'h80123456, 0, 0, 0);
        issue(1, 1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 0, 0, 0);
        issue(1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 0, 0);
        issue(1, 0, 3'b010, 32'h300, 32'h0, 32'h12345678, 3, 2, 1);
        issue(1, 0, 3'b010, 32'h304, 32'h0, 32'h0, 10, 0, 0);
        issue(0, 0, 3'b000, 32'h55, 32'h0, 32'h0, 0, 0, 0);

        for (int i = 0; i < 300; i++) begin
            r      = $urandom_range(0, 9);
            is_mem = (r < 7);
            is_st  = 1'($urandom % 2);
            f3     = 3'($urandom);
            a      = $urandom;
            if ($urandom_range(0, 3) != 0) f3 = {f3[2], 1'b0, f3[0]};
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'($urandom_range(0, 1) * 2);
            w  = $urandom_range(0, 4);
            r  = $urandom_range(0, 7);
            fm = (r < 5) ? 0 : r - 4;
            fb = $urandom_range(1, (w + 1 < TO) ? w + 1 : TO);
            issue(is_mem, is_st, f3, a, $urandom, $urandom, w, fm, fb);
            if ($urandom_range(0, 4) == 0) bubble();
        end

        // reset while a load is outstanding
        q.push_back('{kind: EV_REQ, chk_dload: 1'b0, chk_wdata: 1'b0, dload: 32'd0,
                      addr: 32'h400, wdata: 32'd0, strb: 4'hF, we: 1'b0});
        @(posedge clk); #1;
        in_valid = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; funct3 = 3'b010;
        alu_out = 32'h400; flush = 1'b0; dmem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; mem_rd = 1'b0;
        @(negedge clk);
        chk("req_after_rst", 32'(dmem_req), 32'd0);
        chk("stall_after_rst", 32'(stall), 32'd0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
